// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the EX-stage ALU with iterative multiply/divide.
//   - ALU_* : alu_ctrl op-code values
//   - md_state_e : multiply/divide engine states (IDLE / RUN / FIX)
package alu_pkg;

   localparam int unsigned ALU_NOP  = 0;
   localparam int unsigned ALU_ADD  = 1;
   localparam int unsigned ALU_ADDU = 2;
   localparam int unsigned ALU_SUB  = 3;
   localparam int unsigned ALU_SUBU = 4;
   localparam int unsigned ALU_AND  = 5;
   localparam int unsigned ALU_OR   = 6;
   localparam int unsigned ALU_XOR  = 7;
   localparam int unsigned ALU_NOR  = 8;
   localparam int unsigned ALU_SLT  = 9;
   localparam int unsigned ALU_SLTU = 10;
   localparam int unsigned ALU_SLL  = 11;
   localparam int unsigned ALU_SRL  = 12;
   localparam int unsigned ALU_SRA  = 13;
   localparam int unsigned ALU_SLLV = 14;
   localparam int unsigned ALU_SRLV = 15;
   localparam int unsigned ALU_SRAV = 16;
   localparam int unsigned ALU_LUI  = 17;
   localparam int unsigned ALU_MFHI = 18;
   localparam int unsigned ALU_MFLO = 19;
   localparam int unsigned ALU_MTHI = 20;
   localparam int unsigned ALU_MTLO = 21;
   localparam int unsigned ALU_MULT = 22;
   localparam int unsigned ALU_MULTU = 23;
   localparam int unsigned ALU_DIV  = 24;
   localparam int unsigned ALU_DIVU = 25;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      FIX
   } md_state_e;

endpackage

// File: rtl/muldiv_iter.sv
// muldiv_iter: radix-2 iterative multiply/divide engine owning the HI/LO registers.
//   clk, reset    : clock, synchronous active-high reset (aborts any operation)
//   start         : launch MULT/DIV with a, b (only honoured while idle)
//   div           : 1 = divide, 0 = multiply
//   sgn           : signed operation
//   wr_hi, wr_lo  : MTHI/MTLO write of a (only honoured while idle)
//   a, b          : operands
//   busy          : operation in progress (RUN or FIX)
//   md_done       : one-cycle pulse after HI/LO are written by a MULT/DIV
//   hi, lo        : architectural HI/LO registers
module muldiv_iter
   import alu_pkg::*;
#(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             div,
   input  logic             sgn,
   input  logic             wr_hi,
   input  logic             wr_lo,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             md_done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CNT_W = $clog2(WIDTH);

   md_state_e          state;
   logic [CNT_W-1:0]   cnt;
   // acc: upper product half (multiply) or partial remainder (divide);
   // qr: multiplier shifting out / quotient shifting in.
   logic [WIDTH:0]     acc;
   logic [WIDTH-1:0]   qr;
   logic [WIDTH-1:0]   opnd;
   logic [WIDTH-1:0]   a_keep;
   logic               div_mode;
   logic               neg_q;
   logic               neg_r;
   logic               div_zero;

   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH:0]     add_sum;
   logic [WIDTH:0]     rem_sh;
   logic [WIDTH+1:0]   trial;
   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prod_fix;
   logic [WIDTH-1:0]   quo_fix;
   logic [WIDTH-1:0]   rem_fix;

   assign a_mag   = (sgn && a[WIDTH-1]) ? -a : a;
   assign b_mag   = (sgn && b[WIDTH-1]) ? -b : b;

   assign add_sum = qr[0] ? acc + {1'b0, opnd} : acc;
   assign rem_sh  = {acc[WIDTH-1:0], qr[WIDTH-1]};
   // Extra top bit so a remainder using bit WIDTH is not mistaken for a borrow.
   assign trial   = {1'b0, rem_sh} - {2'b00, opnd};

   assign prod     = {acc[WIDTH-1:0], qr};
   assign prod_fix = neg_q ? -prod : prod;
   assign quo_fix  = neg_q ? -qr : qr;
   assign rem_fix  = neg_r ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];

   assign busy = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         qr       <= '0;
         opnd     <= '0;
         a_keep   <= '0;
         div_mode <= 1'b0;
         neg_q    <= 1'b0;
         neg_r    <= 1'b0;
         div_zero <= 1'b0;
         hi       <= '0;
         lo       <= '0;
         md_done  <= 1'b0;
      end else begin
         md_done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= RUN;
                  cnt      <= '0;
                  acc      <= '0;
                  qr       <= a_mag;
                  opnd     <= b_mag;
                  a_keep   <= a;
                  div_mode <= div;
                  neg_q    <= sgn && (a[WIDTH-1] ^ b[WIDTH-1]);
                  neg_r    <= sgn && a[WIDTH-1];
                  div_zero <= div && (b == '0);
               end else begin
                  if (wr_hi) hi <= a;
                  if (wr_lo) lo <= a;
               end
            end
            RUN: begin
               if (div_mode) begin
                  if (!trial[WIDTH+1]) begin
                     acc <= trial[WIDTH:0];
                     qr  <= {qr[WIDTH-2:0], 1'b1};
                  end else begin
                     acc <= rem_sh;
                     qr  <= {qr[WIDTH-2:0], 1'b0};
                  end
               end else begin
                  acc <= {1'b0, add_sum[WIDTH:1]};
                  qr  <= {add_sum[0], qr[WIDTH-1:1]};
               end
               cnt <= cnt + 1'b1;
               if (cnt == CNT_W'(WIDTH-1)) state <= FIX;
            end
            FIX: begin
               // Divide by zero bypasses sign fix-up: lo all-ones, hi = original a.
               if (div_zero) begin
                  lo <= '1;
                  hi <= a_keep;
               end else if (div_mode) begin
                  lo <= quo_fix;
                  hi <= rem_fix;
               end else begin
                  {hi, lo} <= prod_fix;
               end
               md_done <= 1'b1;
               state   <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU with HI/LO and an iterative multiply/divide engine.
//   clk, reset : clock, synchronous active-high reset
//   alu_ctrl   : op code (alu_pkg ALU_*)
//   a, b       : operands (rs, rt); shamt: immediate shift amount
//   in_valid   : alu_ctrl/a/b valid; in_ready: engine idle (accept = in_valid & in_ready)
//   out, zero, ovf : combinational result, out==0, signed ADD/SUB overflow
//   busy, md_done  : engine running, one-cycle HI/LO-updated pulse
//   hi, lo         : architectural HI/LO
module alu_muldiv
   import alu_pkg::*;
#(
   parameter  int unsigned WIDTH   = 32,
   parameter  int unsigned OP_W    = 5,
   localparam int unsigned SHAMT_W = $clog2(WIDTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [OP_W-1:0]    alu_ctrl,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [SHAMT_W-1:0] shamt,
   input  logic               in_valid,
   output logic               in_ready,
   output logic [WIDTH-1:0]   out,
   output logic               zero,
   output logic               ovf,
   output logic               busy,
   output logic               md_done,
   output logic [WIDTH-1:0]   hi,
   output logic [WIDTH-1:0]   lo
);

   logic [WIDTH-1:0]   sum;
   logic [WIDTH-1:0]   diff;
   logic [SHAMT_W-1:0] vamt;
   logic               slt;
   logic               sltu;
   logic               accept;
   logic               is_md;
   logic               md_div;
   logic               md_sgn;
   logic               wr_hi;
   logic               wr_lo;

   assign sum  = a + b;
   assign diff = a - b;
   assign vamt = a[SHAMT_W-1:0];
   assign slt  = $signed(a) < $signed(b);
   assign sltu = a < b;

   always_comb begin
      out = '0;
      ovf = 1'b0;
      case (alu_ctrl)
         OP_W'(ALU_ADD): begin
            out = sum;
            ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
         end
         OP_W'(ALU_ADDU): out = sum;
         OP_W'(ALU_SUB): begin
            out = diff;
            ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
         end
         OP_W'(ALU_SUBU): out = diff;
         OP_W'(ALU_AND):  out = a & b;
         OP_W'(ALU_OR):   out = a | b;
         OP_W'(ALU_XOR):  out = a ^ b;
         OP_W'(ALU_NOR):  out = ~(a | b);
         OP_W'(ALU_SLT):  out = {{(WIDTH-1){1'b0}}, slt};
         OP_W'(ALU_SLTU): out = {{(WIDTH-1){1'b0}}, sltu};
         OP_W'(ALU_SLL):  out = b << shamt;
         OP_W'(ALU_SRL):  out = b >> shamt;
         OP_W'(ALU_SRA):  out = $unsigned($signed(b) >>> shamt);
         OP_W'(ALU_SLLV): out = b << vamt;
         OP_W'(ALU_SRLV): out = b >> vamt;
         OP_W'(ALU_SRAV): out = $unsigned($signed(b) >>> vamt);
         OP_W'(ALU_LUI):  out = b << 16;
         OP_W'(ALU_MFHI): out = hi;
         OP_W'(ALU_MFLO): out = lo;
         default:         out = '0;
      endcase
   end

   assign zero     = (out == '0);
   assign in_ready = ~busy;
   assign accept   = in_valid & in_ready;

   assign is_md  = (alu_ctrl >= OP_W'(ALU_MULT)) && (alu_ctrl <= OP_W'(ALU_DIVU));
   assign md_div = (alu_ctrl == OP_W'(ALU_DIV)) || (alu_ctrl == OP_W'(ALU_DIVU));
   assign md_sgn = (alu_ctrl == OP_W'(ALU_MULT)) || (alu_ctrl == OP_W'(ALU_DIV));
   assign wr_hi  = accept && (alu_ctrl == OP_W'(ALU_MTHI));
   assign wr_lo  = accept && (alu_ctrl == OP_W'(ALU_MTLO));

   muldiv_iter #(
      .WIDTH(WIDTH)
   ) u_muldiv (
      .clk    (clk),
      .reset  (reset),
      .start  (accept && is_md),
      .div    (md_div),
      .sgn    (md_sgn),
      .wr_hi  (wr_hi),
      .wr_lo  (wr_lo),
      .a      (a),
      .b      (b),
      .busy   (busy),
      .md_done(md_done),
      .hi     (hi),
      .lo     (lo)
   );

endmodule
